// File: rtl/saxil_to_host_pkg.sv
// saxil_to_host_pkg
//   Shared types and constants for the AXI-Lite slave to Ibex host bridge.
//   state_e     : bridge FSM state (also exported on the debug port)
//   RESP_*      : AXI-Lite response encodings
//   BE_ALL      : byte enable used for every read request
package saxil_to_host_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      REQ   = 3'd1,
      WAIT  = 3'd2,
      BRESP = 3'd3,
      RRESP = 3'd4
   } state_e;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [3:0] BE_ALL      = 4'hF;

endpackage

// File: rtl/saxil_to_host_hold_reg.sv
// axil_hold_reg
//   One-entry holding register for a single AXI-Lite request channel.
//   in_data/in_valid/in_ready : upstream channel (in_ready is registered)
//   fire                      : in_valid & in_ready, the accepting handshake
//   full/data                 : held entry, visible the cycle after capture
//   clear                     : frees the entry; takes effect at the next edge
module axil_hold_reg
   import saxil_to_host_pkg::*;
#(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] in_data,
   input  logic         in_valid,
   output logic         in_ready,
   output logic         fire,
   input  logic         clear,
   output logic         full,
   output logic [W-1:0] data
);

   logic         full_q, full_d;
   logic         ready_q, ready_d;
   logic [W-1:0] data_q, data_d;

   assign fire = in_valid & ready_q;

   // ready is a flop so it comes up one edge after reset release, and is
   // simply the registered inverse of the next occupancy.
   always_comb begin
      full_d = full_q & ~clear;
      data_d = data_q;
      if (fire) begin
         full_d = 1'b1;
         data_d = in_data;
      end
      ready_d = ~full_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full_q  <= 1'b0;
         ready_q <= 1'b0;
         data_q  <= '0;
      end else begin
         full_q  <= full_d;
         ready_q <= ready_d;
         data_q  <= data_d;
      end
   end

   assign in_ready = ready_q;
   assign full     = full_q;
   assign data     = data_q;

endmodule

// File: rtl/saxil_to_host.sv
// saxil_to_host
//   AXI-Lite slave port bridged onto an Ibex-style requester data port, one
//   transaction in flight. AW, W and AR each land in a one-entry holding
//   register; the FSM picks a ready write or read, issues it on the Ibex port
//   and returns the AXI-Lite response.
//   s_axil_aw*/w*/b*/ar*/r* : AXI-Lite slave channels
//   data_*_o                : Ibex request (registered)
//   data_*_i                : Ibex grant and response
//   dbg_state_o             : current FSM state
//
// Handshakes: every channel transfers on a clock edge where valid and ready
// are both high. A producer holds valid and its payload stable until that
// edge; ready may be high before valid arrives. The Ibex side follows the
// same rule with data_gnt_i as the ready for data_req_o, and data_rvalid_i
// is a single-cycle strobe accepted only while waiting for it.
module saxil_to_host
   import saxil_to_host_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int AXIL_WIDTH = 32,
   parameter int STRB_WIDTH = AXIL_WIDTH / 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
   input  logic                  s_axil_awvalid,
   output logic                  s_axil_awready,
   input  logic [AXIL_WIDTH-1:0] s_axil_wdata,
   input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
   input  logic                  s_axil_wvalid,
   output logic                  s_axil_wready,
   output logic [1:0]            s_axil_bresp,
   output logic                  s_axil_bvalid,
   input  logic                  s_axil_bready,
   input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
   input  logic                  s_axil_arvalid,
   output logic                  s_axil_arready,
   output logic [AXIL_WIDTH-1:0] s_axil_rdata,
   output logic [1:0]            s_axil_rresp,
   output logic                  s_axil_rvalid,
   input  logic                  s_axil_rready,
   output logic                  data_req_o,
   output logic [ADDR_WIDTH-1:0] data_addr_o,
   output logic                  data_we_o,
   output logic [STRB_WIDTH-1:0] data_be_o,
   output logic [AXIL_WIDTH-1:0] data_wdata_o,
   input  logic                  data_gnt_i,
   input  logic                  data_rvalid_i,
   input  logic                  data_err_i,
   input  logic [AXIL_WIDTH-1:0] data_rdata_i,
   output state_e                dbg_state_o
);

   localparam int WW = AXIL_WIDTH + STRB_WIDTH;

   logic                  aw_fire, aw_full, aw_clr;
   logic                  w_fire, w_full, w_clr;
   logic                  ar_fire, ar_full, ar_clr;
   logic [ADDR_WIDTH-1:0] aw_data, ar_data, cur_awaddr, cur_araddr;
   logic [WW-1:0]         w_data, cur_w;
   logic [STRB_WIDTH-1:0] cur_wstrb;
   logic [AXIL_WIDTH-1:0] cur_wdata;
   logic                  wr_rdy, rd_rdy, pick_wr, pick_rd;
   logic                  start_wr, start_rd, start_zero;
   logic                  unused_bits;

   state_e                state_q, state_d;
   logic                  last_wr_q, last_wr_d;
   logic                  req_q, req_d, we_q, we_d;
   logic [STRB_WIDTH-1:0] be_q, be_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [AXIL_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
   logic                  bvalid_q, bvalid_d, rvalid_q, rvalid_d;
   logic [1:0]            resp_q, resp_d;

   axil_hold_reg #(.W(ADDR_WIDTH)) u_aw (
      .clk(clk), .rst_n(rst_n), .in_data(s_axil_awaddr), .in_valid(s_axil_awvalid),
      .in_ready(s_axil_awready), .fire(aw_fire), .clear(aw_clr), .full(aw_full), .data(aw_data)
   );

   axil_hold_reg #(.W(WW)) u_w (
      .clk(clk), .rst_n(rst_n), .in_data({s_axil_wstrb, s_axil_wdata}), .in_valid(s_axil_wvalid),
      .in_ready(s_axil_wready), .fire(w_fire), .clear(w_clr), .full(w_full), .data(w_data)
   );

   axil_hold_reg #(.W(ADDR_WIDTH)) u_ar (
      .clk(clk), .rst_n(rst_n), .in_data(s_axil_araddr), .in_valid(s_axil_arvalid),
      .in_ready(s_axil_arready), .fire(ar_fire), .clear(ar_clr), .full(ar_full), .data(ar_data)
   );

   // A handshake happening this cycle counts as already held, so the request
   // flops load on the same edge that fills the holding register.
   assign cur_awaddr = aw_full ? aw_data : s_axil_awaddr;
   assign cur_araddr = ar_full ? ar_data : s_axil_araddr;
   assign cur_w      = w_full ? w_data : {s_axil_wstrb, s_axil_wdata};
   assign cur_wstrb  = cur_w[AXIL_WIDTH +: STRB_WIDTH];
   assign cur_wdata  = cur_w[AXIL_WIDTH-1:0];

   assign wr_rdy  = (aw_full | aw_fire) & (w_full | w_fire);
   assign rd_rdy  = ar_full | ar_fire;
   assign pick_wr = wr_rdy & (~rd_rdy | ~last_wr_q);
   assign pick_rd = rd_rdy & ~pick_wr;

   // Word-aligned requests only; the byte offset is carried by data_be_o.
   assign unused_bits = ^{cur_awaddr[1:0], cur_araddr[1:0]};

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         last_wr_q <= 1'b0;
         req_q     <= 1'b0;
         we_q      <= 1'b0;
         be_q      <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         bvalid_q  <= 1'b0;
         rvalid_q  <= 1'b0;
         resp_q    <= RESP_OKAY;
      end else begin
         state_q   <= state_d;
         last_wr_q <= last_wr_d;
         req_q     <= req_d;
         we_q      <= we_d;
         be_q      <= be_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         bvalid_q  <= bvalid_d;
         rvalid_q  <= rvalid_d;
         resp_q    <= resp_d;
      end
   end

   // Next state. A zero-strobe write completes without touching the Ibex
   // port, but only once both halves sit in their holding registers so they
   // can be freed together; while either is still arriving it waits a cycle.
   always_comb begin
      state_d    = state_q;
      start_wr   = 1'b0;
      start_rd   = 1'b0;
      start_zero = 1'b0;
      case (state_q)
         IDLE: begin
            if (pick_wr) begin
               if (cur_wstrb == '0) begin
                  if (aw_full && w_full) begin
                     start_zero = 1'b1;
                     state_d    = BRESP;
                  end
               end else begin
                  start_wr = 1'b1;
                  state_d  = REQ;
               end
            end else if (pick_rd) begin
               start_rd = 1'b1;
               state_d  = REQ;
            end
         end
         REQ:     if (data_gnt_i)    state_d = WAIT;
         WAIT:    if (data_rvalid_i) state_d = we_q ? BRESP : RRESP;
         BRESP:   if (s_axil_bready) state_d = IDLE;
         RRESP:   if (s_axil_rready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output and datapath flop inputs
   always_comb begin
      last_wr_d = last_wr_q;
      req_d     = req_q;
      we_d      = we_q;
      be_d      = be_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      bvalid_d  = bvalid_q;
      rvalid_d  = rvalid_q;
      resp_d    = resp_q;
      aw_clr    = 1'b0;
      w_clr     = 1'b0;
      ar_clr    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_wr) begin
               req_d     = 1'b1;
               we_d      = 1'b1;
               addr_d    = {cur_awaddr[ADDR_WIDTH-1:2], 2'b00};
               be_d      = cur_wstrb;
               wdata_d   = cur_wdata;
               last_wr_d = 1'b1;
            end else if (start_rd) begin
               req_d     = 1'b1;
               we_d      = 1'b0;
               addr_d    = {cur_araddr[ADDR_WIDTH-1:2], 2'b00};
               be_d      = BE_ALL;
               last_wr_d = 1'b0;
            end else if (start_zero) begin
               bvalid_d  = 1'b1;
               resp_d    = RESP_OKAY;
               last_wr_d = 1'b1;
               aw_clr    = 1'b1;
               w_clr     = 1'b1;
            end
         end
         REQ: if (data_gnt_i) req_d = 1'b0;
         WAIT: begin
            if (data_rvalid_i) begin
               resp_d = data_err_i ? RESP_SLVERR : RESP_OKAY;
               if (we_q) begin
                  bvalid_d = 1'b1;
                  aw_clr   = 1'b1;
                  w_clr    = 1'b1;
               end else begin
                  rvalid_d = 1'b1;
                  rdata_d  = data_rdata_i;
                  ar_clr   = 1'b1;
               end
            end
         end
         BRESP: if (s_axil_bready) bvalid_d = 1'b0;
         RRESP: if (s_axil_rready) rvalid_d = 1'b0;
         default: ;
      endcase
   end

   assign data_req_o    = req_q;
   assign data_we_o     = we_q;
   assign data_be_o     = be_q;
   assign data_addr_o   = addr_q;
   assign data_wdata_o  = wdata_q;
   assign s_axil_bvalid = bvalid_q;
   assign s_axil_bresp  = resp_q;
   assign s_axil_rvalid = rvalid_q;
   assign s_axil_rresp  = resp_q;
   assign s_axil_rdata  = rdata_q;
   assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_saxil_to_host.sv
// tb_saxil_to_host
//   Directed bench for saxil_to_host. Inputs change 1 time unit after the
//   rising edge and outputs are sampled there too, so "cycle N" below means
//   the N-th clock period after the edge that completed the last AXI
//   handshake.
module tb_saxil_to_host;
   import saxil_to_host_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] s_axil_awaddr = '0;
   logic        s_axil_awvalid = 1'b0;
   logic        s_axil_awready;
   logic [31:0] s_axil_wdata = '0;
   logic [3:0]  s_axil_wstrb = '0;
   logic        s_axil_wvalid = 1'b0;
   logic        s_axil_wready;
   logic [1:0]  s_axil_bresp;
   logic        s_axil_bvalid;
   logic        s_axil_bready = 1'b0;
   logic [31:0] s_axil_araddr = '0;
   logic        s_axil_arvalid = 1'b0;
   logic        s_axil_arready;
   logic [31:0] s_axil_rdata;
   logic [1:0]  s_axil_rresp;
   logic        s_axil_rvalid;
   logic        s_axil_rready = 1'b0;
   logic        data_req_o;
   logic [31:0] data_addr_o;
   logic        data_we_o;
   logic [3:0]  data_be_o;
   logic [31:0] data_wdata_o;
   logic        data_gnt_i = 1'b0;
   logic        data_rvalid_i = 1'b0;
   logic        data_err_i = 1'b0;
   logic [31:0] data_rdata_i = '0;
   state_e      dbg_state;

   int checks = 0;
   int failures = 0;

   saxil_to_host dut (
      .clk(clk), .rst_n(rst_n),
      .s_axil_awaddr(s_axil_awaddr), .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
      .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb), .s_axil_wvalid(s_axil_wvalid),
      .s_axil_wready(s_axil_wready),
      .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready),
      .s_axil_araddr(s_axil_araddr), .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
      .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp), .s_axil_rvalid(s_axil_rvalid),
      .s_axil_rready(s_axil_rready),
      .data_req_o(data_req_o), .data_addr_o(data_addr_o), .data_we_o(data_we_o),
      .data_be_o(data_be_o), .data_wdata_o(data_wdata_o),
      .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i), .data_err_i(data_err_i),
      .data_rdata_i(data_rdata_i),
      .dbg_state_o(dbg_state)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Presents AW+W and/or AR for one cycle; callers ensure the readies are up.
   task automatic axi_present(input bit do_wr, input bit do_rd, input logic [31:0] waddr,
                              input logic [31:0] wdata, input logic [3:0] wstrb,
                              input logic [31:0] raddr);
      s_axil_awaddr  = waddr;
      s_axil_wdata   = wdata;
      s_axil_wstrb   = wstrb;
      s_axil_awvalid = do_wr;
      s_axil_wvalid  = do_wr;
      s_axil_araddr  = raddr;
      s_axil_arvalid = do_rd;
      step();
      s_axil_awvalid = 1'b0;
      s_axil_wvalid  = 1'b0;
      s_axil_arvalid = 1'b0;
   endtask

   // Ibex target: waits for a request, grants at once, responds next cycle,
   // then waits for the AXI response (bready/rready held high by caller).
   task automatic run_issue(output logic we_seen, output logic [31:0] addr_seen, output bit timeout);
      int n;
      timeout   = 1'b0;
      we_seen   = 1'b0;
      addr_seen = '0;
      n = 0;
      while (!data_req_o && n < 20) begin
         step();
         n++;
      end
      if (!data_req_o) begin
         timeout = 1'b1;
         return;
      end
      we_seen   = data_we_o;
      addr_seen = data_addr_o;
      data_gnt_i = 1'b1;
      step();
      data_gnt_i    = 1'b0;
      data_rvalid_i = 1'b1;
      data_rdata_i  = 32'h0BAD_F00D;
      step();
      data_rvalid_i = 1'b0;
      n = 0;
      while (!(s_axil_bvalid || s_axil_rvalid) && n < 10) begin
         step();
         n++;
      end
      if (!(s_axil_bvalid || s_axil_rvalid)) begin
         timeout = 1'b1;
         return;
      end
      step();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [110:0] outs;
      rst_n = 1'b0;
      step();
      step();
      outs = {s_axil_awready, s_axil_wready, s_axil_arready, s_axil_bvalid, s_axil_bresp,
              s_axil_rvalid, s_axil_rresp, s_axil_rdata, data_req_o, data_we_o, data_be_o,
              data_addr_o, data_wdata_o};
      checks++;
      if (outs !== '0) begin
         failures++;
         $display("FAIL reset_outputs: got %h expected 0", outs);
      end
      checks++;
      if (dbg_state !== IDLE) begin
         failures++;
         $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE);
      end
      rst_n = 1'b1;
      checks++;
      if ({s_axil_awready, s_axil_wready, s_axil_arready} !== 3'b000) begin
         failures++;
         $display("FAIL ready_before_edge: got %b expected 000",
                  {s_axil_awready, s_axil_wready, s_axil_arready});
      end
      step();
      checks++;
      if ({s_axil_awready, s_axil_wready, s_axil_arready} !== 3'b111) begin
         failures++;
         $display("FAIL ready_after_edge: got %b expected 111",
                  {s_axil_awready, s_axil_wready, s_axil_arready});
      end
   endtask

   task automatic test_write_read();
      axi_present(1'b1, 1'b0, 32'h1000, 32'hDEAD_BEEF, 4'hF, 32'h0);
      // cycle 1
      checks++;
      if ({data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o} !==
          {1'b1, 1'b1, 4'hF, 32'h1000, 32'hDEAD_BEEF}) begin
         failures++;
         $display("FAIL wr_request: got %h expected %h",
                  {data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o},
                  {1'b1, 1'b1, 4'hF, 32'h1000, 32'hDEAD_BEEF});
      end
      data_gnt_i = 1'b1;
      step();
      // cycle 2
      data_gnt_i = 1'b0;
      checks++;
      if ({data_req_o, s_axil_bvalid} !== 2'b00) begin
         failures++;
         $display("FAIL wr_cycle2: got req,bvalid=%b expected 00", {data_req_o, s_axil_bvalid});
      end
      data_rvalid_i = 1'b1;
      data_err_i    = 1'b0;
      step();
      // cycle 3
      data_rvalid_i = 1'b0;
      checks++;
      if ({s_axil_bvalid, s_axil_bresp} !== {1'b1, RESP_OKAY}) begin
         failures++;
         $display("FAIL wr_bresp: got %b expected 100", {s_axil_bvalid, s_axil_bresp});
      end
      s_axil_bready = 1'b1;
      step();
      s_axil_bready = 1'b0;
      checks++;
      if (s_axil_bvalid !== 1'b0) begin
         failures++;
         $display("FAIL wr_bvalid_drop: got %b expected 0", s_axil_bvalid);
      end

      // Read back through an unaligned address; the request is word aligned.
      axi_present(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h1002);
      checks++;
      if ({data_req_o, data_we_o, data_be_o, data_addr_o} !== {1'b1, 1'b0, 4'hF, 32'h1000}) begin
         failures++;
         $display("FAIL rd_request: got %h expected %h",
                  {data_req_o, data_we_o, data_be_o, data_addr_o}, {1'b1, 1'b0, 4'hF, 32'h1000});
      end
      data_gnt_i = 1'b1;
      step();
      data_gnt_i    = 1'b0;
      data_rvalid_i = 1'b1;
      data_rdata_i  = 32'hDEAD_BEEF;
      step();
      data_rvalid_i = 1'b0;
      data_rdata_i  = '0;
      checks++;
      if ({s_axil_rvalid, s_axil_rresp, s_axil_rdata} !== {1'b1, RESP_OKAY, 32'hDEAD_BEEF}) begin
         failures++;
         $display("FAIL rd_response: got %h expected %h",
                  {s_axil_rvalid, s_axil_rresp, s_axil_rdata}, {1'b1, RESP_OKAY, 32'hDEAD_BEEF});
      end
      s_axil_rready = 1'b1;
      step();
      s_axil_rready = 1'b0;
      checks++;
      if (s_axil_rvalid !== 1'b0) begin
         failures++;
         $display("FAIL rd_rvalid_drop: got %b expected 0", s_axil_rvalid);
      end
   endtask

   task automatic test_w_before_aw();
      int req_cnt = 0;
      step();
      s_axil_wdata  = 32'h1234_5678;
      s_axil_wstrb  = 4'h3;
      s_axil_wvalid = 1'b1;
      step();
      s_axil_wvalid = 1'b0;
      checks++;
      if (s_axil_wready !== 1'b0) begin
         failures++;
         $display("FAIL w_held: wready got %b expected 0", s_axil_wready);
      end
      for (int i = 0; i < 2; i++) begin
         if (data_req_o) req_cnt++;
         step();
      end
      if (data_req_o) req_cnt++;
      s_axil_awaddr  = 32'h2006;
      s_axil_awvalid = 1'b1;
      step();
      s_axil_awvalid = 1'b0;
      checks++;
      if ({data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o} !==
          {1'b1, 1'b1, 4'h3, 32'h2004, 32'h1234_5678}) begin
         failures++;
         $display("FAIL w_first_request: got %h expected %h",
                  {data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o},
                  {1'b1, 1'b1, 4'h3, 32'h2004, 32'h1234_5678});
      end
      if (data_req_o) req_cnt++;
      data_gnt_i = 1'b1;
      step();
      data_gnt_i    = 1'b0;
      data_rvalid_i = 1'b1;
      if (data_req_o) req_cnt++;
      step();
      data_rvalid_i = 1'b0;
      s_axil_bready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (data_req_o) req_cnt++;
         step();
      end
      s_axil_bready = 1'b0;
      checks++;
      if (req_cnt != 1) begin
         failures++;
         $display("FAIL w_first_req_count: got %0d expected 1", req_cnt);
      end
      checks++;
      if ({s_axil_awready, s_axil_wready} !== 2'b11) begin
         failures++;
         $display("FAIL w_first_ready_back: got %b expected 11", {s_axil_awready, s_axil_wready});
      end
   endtask

   task automatic test_grant_stall();
      step();
      axi_present(1'b1, 1'b0, 32'h3000, 32'hA5A5_5A5A, 4'hF, 32'h0);
      for (int c = 1; c <= 6; c++) begin
         checks++;
         if ({data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o} !==
             {1'b1, 1'b1, 4'hF, 32'h3000, 32'hA5A5_5A5A}) begin
            failures++;
            $display("FAIL stall_hold c%0d: got %h expected %h", c,
                     {data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o},
                     {1'b1, 1'b1, 4'hF, 32'h3000, 32'hA5A5_5A5A});
         end
         if (c == 6) data_gnt_i = 1'b1;
         step();
      end
      // cycle 7
      data_gnt_i = 1'b0;
      checks++;
      if ({data_req_o, s_axil_bvalid} !== 2'b00) begin
         failures++;
         $display("FAIL stall_cycle7: got req,bvalid=%b expected 00", {data_req_o, s_axil_bvalid});
      end
      data_rvalid_i = 1'b1;
      step();
      // cycle 8
      data_rvalid_i = 1'b0;
      checks++;
      if ({s_axil_bvalid, s_axil_bresp} !== {1'b1, RESP_OKAY}) begin
         failures++;
         $display("FAIL stall_bvalid_c8: got %b expected 100", {s_axil_bvalid, s_axil_bresp});
      end
      s_axil_bready = 1'b1;
      step();
      s_axil_bready = 1'b0;
   endtask

   task automatic test_err_backpressure();
      step();
      axi_present(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h4000);
      data_gnt_i = 1'b1;
      step();
      data_gnt_i    = 1'b0;
      data_rvalid_i = 1'b1;
      data_err_i    = 1'b1;
      data_rdata_i  = 32'hCAFE_F00D;
      step();
      data_rvalid_i = 1'b0;
      data_err_i    = 1'b0;
      data_rdata_i  = '0;
      for (int i = 0; i < 5; i++) begin
         if (i == 4) s_axil_rready = 1'b1;
         checks++;
         if ({s_axil_rvalid, s_axil_rresp, s_axil_rdata} !== {1'b1, RESP_SLVERR, 32'hCAFE_F00D}) begin
            failures++;
            $display("FAIL err_hold i%0d: got %h expected %h", i,
                     {s_axil_rvalid, s_axil_rresp, s_axil_rdata}, {1'b1, RESP_SLVERR, 32'hCAFE_F00D});
         end
         step();
      end
      s_axil_rready = 1'b0;
      checks++;
      if (s_axil_rvalid !== 1'b0) begin
         failures++;
         $display("FAIL err_rvalid_drop: got %b expected 0", s_axil_rvalid);
      end
   endtask

   // Last issued before this test is a read, so the first tie goes to the
   // write, then the read. A lone write follows, making the second tie go to
   // the read first.
   task automatic test_tie();
      logic        exp_we [5];
      logic [31:0] exp_addr [5];
      logic        got_we;
      logic [31:0] got_addr;
      bit          to;
      exp_we   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      exp_addr = '{32'h7000, 32'h7100, 32'h7200, 32'h7400, 32'h7300};
      s_axil_bready = 1'b1;
      s_axil_rready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         if (k == 0 || k == 2 || k == 3) begin
            step();
            step();
            checks++;
            if ({s_axil_awready, s_axil_wready, s_axil_arready} !== 3'b111) begin
               failures++;
               $display("FAIL tie_ready k%0d: got %b expected 111", k,
                        {s_axil_awready, s_axil_wready, s_axil_arready});
            end
            if (k == 0) axi_present(1'b1, 1'b1, 32'h7000, 32'h1, 4'hF, 32'h7100);
            if (k == 2) axi_present(1'b1, 1'b0, 32'h7200, 32'h2, 4'hF, 32'h0);
            if (k == 3) axi_present(1'b1, 1'b1, 32'h7300, 32'h3, 4'hF, 32'h7400);
         end
         run_issue(got_we, got_addr, to);
         checks++;
         if (to || {got_we, got_addr} !== {exp_we[k], exp_addr[k]}) begin
            failures++;
            $display("FAIL tie_order k%0d: got we=%b addr=%h timeout=%0d expected we=%b addr=%h",
                     k, got_we, got_addr, to, exp_we[k], exp_addr[k]);
         end
      end
      s_axil_bready = 1'b0;
      s_axil_rready = 1'b0;
   endtask

   task automatic test_zero_strobe();
      int req_cnt = 0;
      step();
      axi_present(1'b1, 1'b0, 32'h5000, 32'hFFFF_FFFF, 4'h0, 32'h0);
      // cycle 1
      if (data_req_o) req_cnt++;
      checks++;
      if (s_axil_bvalid !== 1'b0) begin
         failures++;
         $display("FAIL zs_bvalid_c1: got %b expected 0", s_axil_bvalid);
      end
      step();
      // cycle 2
      if (data_req_o) req_cnt++;
      checks++;
      if ({s_axil_bvalid, s_axil_bresp} !== {1'b1, RESP_OKAY}) begin
         failures++;
         $display("FAIL zs_bresp_c2: got %b expected 100", {s_axil_bvalid, s_axil_bresp});
      end
      s_axil_bready = 1'b1;
      step();
      s_axil_bready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (data_req_o) req_cnt++;
         step();
      end
      checks++;
      if (req_cnt != 0) begin
         failures++;
         $display("FAIL zs_no_request: got %0d request cycles expected 0", req_cnt);
      end
      checks++;
      if ({s_axil_awready, s_axil_wready, s_axil_bvalid} !== 3'b110) begin
         failures++;
         $display("FAIL zs_after: got aw,w,b=%b expected 110",
                  {s_axil_awready, s_axil_wready, s_axil_bvalid});
      end
   endtask

   task automatic test_reset_mid();
      logic [110:0] outs;
      int           late = 0;
      step();
      axi_present(1'b1, 1'b0, 32'h6000, 32'h1111_2222, 4'hF, 32'h0);
      data_gnt_i = 1'b1;
      step();
      // in WAIT now
      data_gnt_i = 1'b0;
      rst_n = 1'b0;
      #1;
      outs = {s_axil_awready, s_axil_wready, s_axil_arready, s_axil_bvalid, s_axil_bresp,
              s_axil_rvalid, s_axil_rresp, s_axil_rdata, data_req_o, data_we_o, data_be_o,
              data_addr_o, data_wdata_o};
      checks++;
      if (outs !== '0 || dbg_state !== IDLE) begin
         failures++;
         $display("FAIL mid_reset_outputs: got %h state %0d expected 0 state 0", outs, dbg_state);
      end
      step();
      rst_n = 1'b1;
      data_rvalid_i = 1'b1;
      data_err_i    = 1'b1;
      step();
      data_rvalid_i = 1'b0;
      data_err_i    = 1'b0;
      s_axil_bready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (s_axil_bvalid || s_axil_rvalid || data_req_o) late++;
         step();
      end
      s_axil_bready = 1'b0;
      checks++;
      if (late != 0) begin
         failures++;
         $display("FAIL mid_reset_late_rvalid: got %0d active cycles expected 0", late);
      end
      checks++;
      if ({s_axil_awready, s_axil_wready, s_axil_arready} !== 3'b111) begin
         failures++;
         $display("FAIL mid_reset_ready: got %b expected 111",
                  {s_axil_awready, s_axil_wready, s_axil_arready});
      end
   endtask

   // ---------------- sequence / report ----------------
   initial begin
      test_reset();
      test_write_read();
      test_w_before_aw();
      test_grant_stall();
      test_err_backpressure();
      test_tie();
      test_zero_strobe();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
